dm_store_buffer: RTL

//   Posted-write store buffer between the store byte-enable stage and the data-memory bus.

---
 rtl/dm_store_buffer_pkg.sv | 13 +
 rtl/dm_store_buffer_if.sv | 33 +++
 rtl/dm_store_buffer_entry_match.sv | 13 +
 rtl/dm_store_buffer.sv | 88 ++++++++
 4 files changed

// File: rtl/dm_store_buffer_pkg.sv
// dm_store_buffer_pkg: shared store-buffer entry and drain-state types (package mips_mem_pkg).
package mips_mem_pkg;
  localparam int SB_DEPTH_DEFAULT = 4;
  localparam logic [3:0] BYTEEN_NONE = 4'b0000;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;
  typedef enum logic {SB_IDLE, SB_REQ} sb_state_t;
endpackage

// File: rtl/dm_store_buffer_if.sv
// dm_store_buffer_if: store, load-check and memory-bus signals of the store buffer.
interface dm_store_buffer_if #(parameter int PTR_W = 2);
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [3:0]       st_byteen;
  logic [31:0]      st_wdata;
  logic [31:0]      st_pc;
  logic             st_ready;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  logic [3:0]       ld_byteen;
  logic             ld_stall;
  logic             ld_fwd_valid;
  logic [31:0]      ld_fwd_data;
  logic             bus_req;
  logic [31:0]      bus_addr;
  logic [3:0]       bus_byteen;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_pc;
  logic             bus_ack;
  logic             sb_empty;
  logic [PTR_W:0]   sb_count;
  modport master (
    output st_valid, st_addr, st_byteen, st_wdata, st_pc, ld_valid, ld_addr, ld_byteen, bus_ack,
    input  st_ready, ld_stall, ld_fwd_valid, ld_fwd_data, bus_req, bus_addr, bus_byteen, bus_wdata,
           bus_pc, sb_empty, sb_count
  );
  modport slave (
    input  st_valid, st_addr, st_byteen, st_wdata, st_pc, ld_valid, ld_addr, ld_byteen, bus_ack,
    output st_ready, ld_stall, ld_fwd_valid, ld_fwd_data, bus_req, bus_addr, bus_byteen, bus_wdata,
           bus_pc, sb_empty, sb_count
  );
endinterface

// File: rtl/dm_store_buffer_entry_match.sv
// sb_entry_match: word-address and byte-lane overlap test of one pending store against a load.
module sb_entry_match (
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  byteen_i,
  input  logic [31:0] ld_addr_i,
  input  logic [3:0]  ld_byteen_i,
  output logic        match_o
);
  logic unused;
  assign unused = ^{addr_i[1:0], ld_addr_i[1:0]};
  assign match_o = valid_i & (addr_i[31:2] == ld_addr_i[31:2]) & |(byteen_i & ld_byteen_i);
endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write FIFO draining to memory over req/ack, with load-overlap stall.
// Define DM_STORE_FWD_EN to forward from the youngest fully-covering pending store instead of stalling.
module dm_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  dm_store_buffer_if.slave  sb
);
  sb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  sb_state_t        state_q, state_d;
  logic             ready, push, pop, any_match;
  logic [DEPTH-1:0] match;
  assign ready = count_q != (PTR_W+1)'(DEPTH);
  assign push = sb.st_valid & ready & (sb.st_byteen != BYTEEN_NONE);
  assign pop = (state_q == SB_REQ) & sb.bus_ack;
  assign count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  always_comb state_d = (state_q == SB_IDLE) ? ((count_q != '0) ? SB_REQ : SB_IDLE)
                                             : ((pop && count_d == '0) ? SB_IDLE : SB_REQ);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= SB_IDLE;
      for (int k = 0; k < DEPTH; k++) entries_q[k].valid <= 1'b0;
    end else begin
      if (push) begin
        entries_q[wr_ptr_q] <= '{1'b1, sb.st_addr, sb.st_byteen, sb.st_wdata, sb.st_pc};
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        entries_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      state_q <= state_d;
    end
  end
  assign sb.st_ready   = ready;
  assign sb.sb_empty   = count_q == '0;
  assign sb.sb_count   = count_q;
  assign sb.bus_req    = state_q == SB_REQ;
  assign sb.bus_addr   = {entries_q[rd_ptr_q].addr[31:2], 2'b00};
  assign sb.bus_byteen = entries_q[rd_ptr_q].byteen;
  assign sb.bus_wdata  = entries_q[rd_ptr_q].data;
  assign sb.bus_pc     = entries_q[rd_ptr_q].pc;
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    sb_entry_match u_match (
      .valid_i     (entries_q[i].valid),
      .addr_i      (entries_q[i].addr),
      .byteen_i    (entries_q[i].byteen),
      .ld_addr_i   (sb.ld_addr),
      .ld_byteen_i (sb.ld_byteen),
      .match_o     (match[i])
    );
  end
  assign any_match = sb.ld_valid & |match;
`ifdef DM_STORE_FWD_EN
  logic [3:0]  y_byteen;
  logic [31:0] y_data;
  logic        fwd;
  // Walk oldest to youngest so the last hit is the youngest; its full coverage hides older lanes.
  always_comb begin
    y_byteen = '0;
    y_data   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[PTR_W'(rd_ptr_q + PTR_W'(k))]) begin
        y_byteen = entries_q[PTR_W'(rd_ptr_q + PTR_W'(k))].byteen;
        y_data   = entries_q[PTR_W'(rd_ptr_q + PTR_W'(k))].data;
      end
    end
  end
  assign fwd             = any_match & ((y_byteen & sb.ld_byteen) == sb.ld_byteen);
  assign sb.ld_stall     = any_match & ~fwd;
  assign sb.ld_fwd_valid = fwd;
  assign sb.ld_fwd_data  = fwd ? y_data : '0;
`else
  assign sb.ld_stall     = any_match;
  assign sb.ld_fwd_valid = 1'b0;
  assign sb.ld_fwd_data  = '0;
`endif
endmodule
